pipe3_hazard_ctrl: RTL and testbench
====================================

Name: pipe3_hazard_ctrl

Overview:
- Central sequencing controller for the 3-stage (IF / ID / EX) pipelined core.
- Each cycle it decides the stage-register write enables, flushes, bubbles and ID-operand forwarding selects.
- It detects load-use hazards, resolves taken branches, holds EX for multi-cycle multiply, and absorbs instruction-fetch stalls.
- Sits beside `pipelined_3stage`'s datapath. All control outputs are combinational from the current FSM state and inputs, so they act in the same cycle.

Parameters:
- MUL_LAT, 4, total EX-occupancy cycles of a multiply (1..15); 1 means single-cycle, no hold.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_AW  ID source register 1.
- id_rs1_used  in  1  id_rs1 is read.
- id_rs2  in  REG_AW  ID source register 2.
- id_rs2_used  in  1  id_rs2 is read.
- ex_valid  in  1  EX holds a real instruction.
- ex_rd  in  REG_AW  EX destination register.
- ex_wr  in  1  EX instruction writes ex_rd.
- ex_load  in  1  EX is a load (data arrives one cycle after EX).
- ex_mul  in  1  EX is a multiply.
- ex_br_taken  in  1  EX resolved a taken branch/jump.
- if_stall  in  1  instruction memory not ready this cycle.
- pc_we  out  1  PC register update enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load NOP into IF/ID (ignored unless ifid_we=1).
- idex_we  out  1  ID/EX register write enable.
- idex_bubble  out  1  load NOP into ID/EX (ignored unless idex_we=1).
- ex_hold  out  1  EX must keep its operands/result registers.
- ex_done  out  1  one-cycle pulse on the final cycle of a multiply.
- fwd_a  out  1  forward EX ALU result to ID operand A.
- fwd_b  out  1  forward EX ALU result to ID operand B.
- stall_cnt  out  32  perf counter (see Optional Feature).
- flush_cnt  out  32  perf counter (see Optional Feature).

Behaviour:
- FSM states: RUN, MUL_WAIT. The counter mcnt is 4 bits wide.
- Reset (rst=1, evaluated at the clock edge):
  - Next state is RUN and mcnt=0.
  - While rst is high, outputs are forced: pc_we=0, ifid_we=1, ifid_flush=1, idex_we=1, idex_bubble=1, ex_hold=0, ex_done=0, fwd_a=0, fwd_b=0.
  - Reset mid-multiply abandons the multiply.
- Hazard terms (register 0 never matches):
  - match_x = id_valid & id_rsx_used & ex_valid & ex_wr & (ex_rd!=0) & (id_rsx==ex_rd).
  - load_use = ex_load & (match_1 | match_2).
  - fwd_a = match_1 & ~ex_load; fwd_b = match_2 & ~ex_load. Forwarding outputs are valid in every state.
- Default (RUN, no event): pc_we=ifid_we=idex_we=1, all flush/bubble/hold=0.
- Priority, highest first:
  1. Multiply hold.
     - In RUN with ex_valid & ex_mul & MUL_LAT>1: go to MUL_WAIT with mcnt=MUL_LAT-2.
     - In that cycle and every MUL_WAIT cycle with mcnt!=0: ex_hold=1, pc_we=ifid_we=idex_we=0. mcnt decrements.
     - In MUL_WAIT with mcnt==0: ex_hold=0, ex_done=1, return to RUN. That cycle is then evaluated under rules 2-4.
     - For MUL_LAT==1, ex_done=1 in the single EX cycle and there is no hold.
     - ex_mul=1 during the ex_done cycle must not retrigger: the instruction advances that cycle.
  2. Branch: ex_br_taken (not under hold) gives pc_we=1, ifid_we=1, ifid_flush=1, idex_we=1, idex_bubble=1. It overrides load_use and if_stall; the redirect is always taken.
  3. Load-use: pc_we=0, ifid_we=0, idex_we=1, idex_bubble=1. This is exactly one stall cycle, because the load leaves EX and the next cycle no longer matches.
  4. if_stall: pc_we=0, ifid_we=1, ifid_flush=1. ID/EX advances normally.
- ex_mul and ex_br_taken together: multiply hold first; branch acts in the ex_done cycle.

Optional Feature:
- Macro: PIPE3_PERF_CNT_EN.
- When defined:
  - stall_cnt increments every cycle in which pc_we=0 and rst=0.
  - flush_cnt increments on each taken-branch flush.
  - Both counters are 32-bit, wrap at 2^32-1 to 0, and clear on rst.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> pc_we=0, ifid_flush=1, idex_bubble=1, fwd_a=fwd_b=0. First cycle after rst drops -> pc_we=1.
- Forward:
  - ex: rd=5, ex_wr=1, ex_load=0; id: rs1=5 used, rs2=5 unused -> fwd_a=1, fwd_b=0, no stall.
  - Repeat with rd=0 -> fwd_a=0.
- Load-use: ex_load=1, rd=7; id rs2=7 used -> exactly one cycle of pc_we=0, ifid_we=0, idex_bubble=1. Next cycle (ex_valid=0) -> default.
- Multiply with MUL_LAT=4: ex_mul held -> ex_hold=1 for 3 cycles, ex_done=1 on the 4th cycle, then RUN.
  - Same with rst asserted in 2nd hold cycle -> RUN next cycle, ex_hold=0.
- Branch with if_stall=1 and load_use true together -> pc_we=1, ifid_flush=1, idex_bubble=1. With PIPE3_PERF_CNT_EN defined, flush_cnt goes 0 -> 1.
- if_stall alone for 3 cycles -> pc_we=0, ifid_flush=1 each cycle, idex_we=1. With PIPE3_PERF_CNT_EN defined, stall_cnt=3.

Source files
------------

// File: rtl/pipe3_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe3_hazard_ctrl
//   Sequencing controller for the 3-stage (IF/ID/EX) core. Every cycle it
//   produces the stage-register write enables, flushes and bubbles, and the
//   ID-operand forwarding selects. It handles load-use stalls, taken-branch
//   redirects, multi-cycle multiply holds in EX and instruction-fetch stalls.
//   All control outputs are combinational from the current state and inputs.
//
// Parameters
//   MUL_LAT  total EX-occupancy cycles of a multiply (1..15)
//   REG_AW   register-index width
//
// Ports
//   clk, rst (sync, active-high)
//   id_*     ID-stage source operands and their use flags
//   ex_*     EX-stage destination, instruction class and branch outcome
//   if_stall instruction memory not ready
//   pc_we, ifid_we/ifid_flush, idex_we/idex_bubble   stage controls
//   ex_hold, ex_done                                  multiply sequencing
//   fwd_a, fwd_b                                      EX->ID forwarding
//   stall_cnt, flush_cnt                              perf counters
//
// Build option
//   PIPE3_PERF_CNT_EN : when defined, stall_cnt counts cycles with pc_we=0
//   and flush_cnt counts taken-branch flushes. Otherwise both read 0.
// ---------------------------------------------------------------------------
module pipe3_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr,
  input  logic              ex_load,
  input  logic              ex_mul,
  input  logic              ex_br_taken,
  input  logic              if_stall,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_we,
  output logic              idex_bubble,
  output logic              ex_hold,
  output logic              ex_done,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  // Remaining hold cycles after the entry cycle; the last MUL_WAIT cycle
  // (mcnt==0) is the ex_done cycle.
  localparam logic [3:0] MCNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] mcnt, mcnt_nxt;
  logic       match_1, match_2, load_use;
  logic       hold, br_flush;

  // r0 is hard-wired zero, so it never creates a dependency
  assign match_1  = id_valid & id_rs1_used & ex_valid & ex_wr &
                    (ex_rd != '0) & (id_rs1 == ex_rd);
  assign match_2  = id_valid & id_rs2_used & ex_valid & ex_wr &
                    (ex_rd != '0) & (id_rs2 == ex_rd);
  assign load_use = ex_load & (match_1 | match_2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      mcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mcnt_nxt    = mcnt;
    hold        = 1'b0;
    br_flush    = 1'b0;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    ex_done     = 1'b0;
    fwd_a       = match_1 & ~ex_load;
    fwd_b       = match_2 & ~ex_load;

    unique case (state)
      RUN: begin
        if (ex_valid && ex_mul) begin
          if (MUL_LAT > 1) begin
            hold      = 1'b1;
            state_nxt = MUL_WAIT;
            mcnt_nxt  = MCNT_INIT;
          end else begin
            ex_done = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        if (mcnt != 4'd0) begin
          hold     = 1'b1;
          mcnt_nxt = mcnt - 4'd1;
        end else begin
          // final cycle: multiply leaves EX, so ex_mul here cannot retrigger
          ex_done   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (hold) begin
      ex_hold = 1'b1;
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
    end else if (ex_br_taken) begin
      // redirect always wins over load-use and fetch stall
      br_flush    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (if_stall) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
    end

    if (rst) begin
      state_nxt   = RUN;
      mcnt_nxt    = 4'd0;
      br_flush    = 1'b0;
      pc_we       = 1'b0;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b1;
      idex_we     = 1'b1;
      idex_bubble = 1'b1;
      ex_hold     = 1'b0;
      ex_done     = 1'b0;
      fwd_a       = 1'b0;
      fwd_b       = 1'b0;
    end
  end

`ifdef PIPE3_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_we)   stall_cnt <= stall_cnt + 32'd1;
      if (br_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
  logic unused_perf;
  assign unused_perf = br_flush;
`endif

endmodule

// File: tb/tb_pipe3_hazard_ctrl.sv
module tb_pipe3_hazard_ctrl;
  localparam int MUL_LAT = 4;
  localparam int REG_AW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_rs1_used, id_rs2_used;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              ex_valid, ex_wr, ex_load, ex_mul, ex_br_taken, if_stall;
  logic              pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
  logic              ex_hold, ex_done, fwd_a, fwd_b;
  logic [31:0]       stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state: cycles the current multiply has spent in EX
  int          mul_age = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;
  logic [8:0]  lo;

  pipe3_hazard_ctrl #(.MUL_LAT(MUL_LAT), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
    .ex_mul(ex_mul), .ex_br_taken(ex_br_taken), .if_stall(if_stall),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_bubble(idex_bubble), .ex_hold(ex_hold),
    .ex_done(ex_done), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rst = 0; id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    ex_valid = 0; ex_rd = 0; ex_wr = 0; ex_load = 0; ex_mul = 0;
    ex_br_taken = 0; if_stall = 0;
  endtask

  task automatic rnd(input bit allow_rst);
    rst         = allow_rst && ($urandom_range(0, 31) == 0);
    id_valid    = $urandom_range(0, 3) != 0;
    id_rs1      = REG_AW'($urandom_range(0, 3));
    id_rs2      = REG_AW'($urandom_range(0, 3));
    id_rs1_used = $urandom_range(0, 1) != 0;
    id_rs2_used = $urandom_range(0, 1) != 0;
    ex_valid    = $urandom_range(0, 3) != 0;
    ex_rd       = REG_AW'($urandom_range(0, 3));
    ex_wr       = $urandom_range(0, 1) != 0;
    ex_load     = $urandom_range(0, 2) == 0;
    ex_mul      = $urandom_range(0, 5) == 0;
    ex_br_taken = $urandom_range(0, 4) == 0;
    if_stall    = $urandom_range(0, 3) == 0;
  endtask

  // Inputs are already driven (just after a falling edge). Evaluate the
  // rules, compare, then advance the model across the rising edge.
  task automatic step(input string tag);
    logic m1, m2, lu, hold, done, flush;
    logic [8:0] e;
    int nxt;
    #2;
    m1 = id_valid & id_rs1_used & ex_valid & ex_wr & (ex_rd != 0) & (id_rs1 == ex_rd);
    m2 = id_valid & id_rs2_used & ex_valid & ex_wr & (ex_rd != 0) & (id_rs2 == ex_rd);
    lu = ex_load & (m1 | m2);
    hold = 0; done = 0; flush = 0; nxt = 0;
    if (mul_age > 0) begin
      if (mul_age + 1 >= MUL_LAT) done = 1;
      else begin hold = 1; nxt = mul_age + 1; end
    end else if (ex_valid && ex_mul) begin
      if (MUL_LAT == 1) done = 1;
      else begin hold = 1; nxt = 1; end
    end
    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, ex_hold, ex_done, fwd_a, fwd_b}
    if (rst)              e = 9'b0_1_1_1_1_0_0_0_0;
    else if (hold)        e = {8'b0_0_0_0_0_1_0_0, 1'b0};
    else if (ex_br_taken) e = {5'b1_1_1_1_1, 2'b00, 2'b00};
    else if (lu)          e = {5'b0_0_0_1_1, 2'b00, 2'b00};
    else if (if_stall)    e = {5'b0_1_1_1_0, 2'b00, 2'b00};
    else                  e = {5'b1_1_0_1_0, 2'b00, 2'b00};
    if (!rst) begin
      e[2] = done;
      e[1] = m1 & ~ex_load;
      e[0] = m2 & ~ex_load;
      flush = !hold && ex_br_taken;
    end
    lo = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, ex_hold, ex_done, fwd_a, fwd_b};
    chk(tag, 64'(lo), 64'(e));
`ifdef PIPE3_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`else
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
`endif
    if (rst) begin
      mul_age = 0; m_stall = 0; m_flush = 0;
    end else begin
      mul_age = nxt;
      if (!e[8]) m_stall = m_stall + 1;
      if (flush) m_flush = m_flush + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] f0;
    clr();
    rst = 1;
    @(negedge clk);

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      rnd(0); rst = 1;
      step("reset");
      chk("reset_pc_we", 64'(lo[8]), 64'd0);
      chk("reset_fwd", 64'(lo[1:0]), 64'd0);
    end
    clr();
    step("post_reset");
    chk("post_reset_pc_we", 64'(lo[8]), 64'd1);

    // forwarding
    clr(); ex_valid = 1; ex_rd = 5; ex_wr = 1;
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_rs2 = 5; id_rs2_used = 0;
    step("fwd_rd5");
    chk("fwd_rd5_a", 64'(lo[1]), 64'd1);
    chk("fwd_rd5_b", 64'(lo[0]), 64'd0);
    chk("fwd_rd5_pc", 64'(lo[8]), 64'd1);
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    step("fwd_rd0");
    chk("fwd_rd0_a", 64'(lo[1]), 64'd0);

    // load-use: one stall cycle, then default
    clr(); ex_valid = 1; ex_rd = 7; ex_wr = 1; ex_load = 1;
    id_valid = 1; id_rs2 = 7; id_rs2_used = 1;
    step("ld_use");
    chk("ld_use_ctl", 64'({lo[8], lo[7], lo[4]}), 64'b001);
    ex_valid = 0;
    step("ld_use_after");
    chk("ld_use_after_pc", 64'(lo[8]), 64'd1);

    // multiply: 3 hold cycles, done on the 4th, then RUN
    clr(); ex_valid = 1; ex_mul = 1; ex_wr = 1; ex_rd = 3;
    for (int i = 0; i < MUL_LAT; i++) begin
      step("mul");
      chk("mul_hold", 64'(lo[3]), 64'(i < MUL_LAT - 1));
      chk("mul_done", 64'(lo[2]), 64'(i == MUL_LAT - 1));
    end
    ex_mul = 0;
    step("mul_run");

    // multiply abandoned by reset in the 2nd hold cycle
    clr(); ex_valid = 1; ex_mul = 1;
    step("mulr_h1");
    rst = 1;
    step("mulr_rst");
    clr();
    step("mulr_after");
    chk("mulr_after_hold", 64'(lo[3]), 64'd0);

    // branch beats load-use and fetch stall
    clr(); rst = 1; step("br_rst");
    clr(); f0 = flush_cnt;
    ex_valid = 1; ex_rd = 7; ex_wr = 1; ex_load = 1; ex_br_taken = 1; if_stall = 1;
    id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
    step("branch");
    chk("branch_ctl", 64'({lo[8], lo[6], lo[4]}), 64'b111);
`ifdef PIPE3_PERF_CNT_EN
    chk("branch_flush_cnt", 64'(flush_cnt), 64'(f0 + 1));
`endif

    // fetch stall alone for 3 cycles after a reset
    clr(); rst = 1; step("ifs_rst");
    clr(); if_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step("if_stall");
      chk("if_stall_ctl", 64'({lo[8], lo[6], lo[5]}), 64'b011);
    end
    clr();
`ifdef PIPE3_PERF_CNT_EN
    chk("if_stall_cnt3", 64'(stall_cnt), 64'd3);
`endif
    step("if_stall_end");

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rnd(1);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
